// File: rtl/elevator_request_scheduler.sv
// LOOK-policy call scheduler: latches call-button rises into a pending mask, drives the elevator FSM target, times the door dwell.
// Call visible one edge after its rise, target and req_active one edge later; door_open is high for DWELL_CYCLES cycles per stop.
module elevator_request_scheduler #(
  parameter int          NUM_FLOORS   = 10,
  parameter logic [31:0] DWELL_CYCLES = 32'd20000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call_btn,
  input  logic [3:0]            current_floor,
  output logic [3:0]            requested_floor,
  output logic                  req_active,
  output logic                  door_open,
  output logic                  dir_up,
  output logic [NUM_FLOORS-1:0] pending
);

  typedef enum logic [1:0] {IDLE, SERVE_UP, SERVE_DOWN, DWELL} state_t;

  state_t                state_q, state_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [NUM_FLOORS-1:0] btn_prev_q;
  logic [3:0]            requested_floor_q, requested_floor_d;
  logic                  req_active_q, req_active_d;
  logic                  door_open_q, door_open_d;
  logic                  dir_up_q, dir_up_d;
  logic [31:0]           dwell_cnt_q, dwell_cnt_d;

  logic [NUM_FLOORS-1:0] rise, cur_mask, clr_mask;
  logic [3:0]            above, below, dist_up, dist_dn;
  logic                  has_above, has_below, here, go_up, go_down;

  // Floors at or beyond NUM_FLOORS never match a pending bit, so "here" is simply false there.
  always_comb begin
    above     = 4'd0;
    below     = 4'd0;
    has_above = 1'b0;
    has_below = 1'b0;
    cur_mask  = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pending_q[i] && (4'(i) > current_floor)) begin
        above     = 4'(i);
        has_above = 1'b1;
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      cur_mask[i] = (4'(i) == current_floor);
      if (pending_q[i] && (4'(i) < current_floor)) begin
        below     = 4'(i);
        has_below = 1'b1;
      end
    end
    here    = |(pending_q & cur_mask);
    dist_up = above - current_floor;
    dist_dn = current_floor - below;
    rise    = call_btn & ~btn_prev_q;
  end

  always_comb begin
    state_d           = state_q;
    requested_floor_d = requested_floor_q;
    req_active_d      = req_active_q;
    door_open_d       = door_open_q;
    dir_up_d          = dir_up_q;
    dwell_cnt_d       = dwell_cnt_q;
    clr_mask          = '0;
    go_up             = 1'b0;
    go_down           = 1'b0;

    case (state_q)
      IDLE: begin
        requested_floor_d = current_floor;
        req_active_d      = 1'b0;
        if (here) begin
          clr_mask    = cur_mask;
          state_d     = DWELL;
          door_open_d = 1'b1;
          dwell_cnt_d = 32'd0;
        end else if (has_above && (!has_below || (dist_up <= dist_dn))) begin
          go_up = 1'b1;
        end else if (has_below) begin
          go_down = 1'b1;
        end
      end
      SERVE_UP, SERVE_DOWN: begin
        // Arrival is judged against the registered target before retargeting.
        if (current_floor == requested_floor_q) begin
          clr_mask          = cur_mask;
          state_d           = DWELL;
          door_open_d       = 1'b1;
          req_active_d      = 1'b0;
          dwell_cnt_d       = 32'd0;
          requested_floor_d = current_floor;
        end else if ((state_q == SERVE_UP) && has_above) begin
          requested_floor_d = above;
        end else if ((state_q == SERVE_DOWN) && has_below) begin
          requested_floor_d = below;
        end
      end
      DWELL: begin
        requested_floor_d = current_floor;
        if (dwell_cnt_q == DWELL_CYCLES - 32'd1) begin
          clr_mask    = cur_mask;
          door_open_d = 1'b0;
          dwell_cnt_d = 32'd0;
          state_d     = IDLE;
          if (dir_up_q && has_above)        go_up   = 1'b1;
          else if (!dir_up_q && has_below)  go_down = 1'b1;
          else if (has_above)               go_up   = 1'b1;
          else if (has_below)               go_down = 1'b1;
        end else begin
          dwell_cnt_d = dwell_cnt_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (go_up) begin
      state_d           = SERVE_UP;
      dir_up_d          = 1'b1;
      req_active_d      = 1'b1;
      requested_floor_d = above;
    end
    if (go_down) begin
      state_d           = SERVE_DOWN;
      dir_up_d          = 1'b0;
      req_active_d      = 1'b1;
      requested_floor_d = below;
    end

    // A clear on the floor being served beats a same-cycle rise.
    pending_d = (pending_q | rise) & ~clr_mask;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= IDLE;
      pending_q         <= '0;
      btn_prev_q        <= '1;
      requested_floor_q <= 4'd0;
      req_active_q      <= 1'b0;
      door_open_q       <= 1'b0;
      dir_up_q          <= 1'b1;
      dwell_cnt_q       <= 32'd0;
    end else begin
      state_q           <= state_d;
      pending_q         <= pending_d;
      btn_prev_q        <= call_btn;
      requested_floor_q <= requested_floor_d;
      req_active_q      <= req_active_d;
      door_open_q       <= door_open_d;
      dir_up_q          <= dir_up_d;
      dwell_cnt_q       <= dwell_cnt_d;
    end
  end

  assign requested_floor = requested_floor_q;
  assign req_active      = req_active_q;
  assign door_open       = door_open_q;
  assign dir_up          = dir_up_q;
  assign pending         = pending_q;

endmodule
